// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - two-requester round-robin arbiter around one shared ALU
//
// Runs one operation at a time through IDLE -> EXEC -> RESP.
// Optional statistics: define ALU_SHARE_ARB_STATS_EN to add saturating grant counters.
//
// Ports:
//   clk, rst                        rising-edge clock, synchronous active-high reset
//   req{0,1}_valid/_ready           requester handshake; ready is combinational, IDLE only
//   req{0,1}_op/_a/_b               00=AND 01=OR 10=XOR 11=ADD, operands
//   res_valid/res_ready             result handshake
//   res_y, res_cout, res_id         result, ADD carry-out, issuing requester
//   busy                            high while in EXEC or RESP
//   grant_cnt0, grant_cnt1          (ALU_SHARE_ARB_STATS_EN only) accepted ops per requester

module alu_share_arbiter #(
  parameter int WIDTH = 4,
  parameter int OPW   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_y,
  output logic             res_cout,
  output logic             res_id,
  output logic             busy
`ifdef ALU_SHARE_ARB_STATS_EN
  ,
  output logic [7:0]       grant_cnt0,
  output logic [7:0]       grant_cnt1
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [OPW-1:0]   op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             id_q;
  logic             last_grant;
  logic             gnt0, gnt1;
  logic             acc0, acc1;
  logic [WIDTH:0]   alu_out;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    gnt0       = req0_valid & (~req1_valid | last_grant);
    gnt1       = req1_valid & (~req0_valid | ~last_grant);
    req0_ready = (state == S_IDLE) & ~rst & gnt0;
    req1_ready = (state == S_IDLE) & ~rst & gnt1;
    acc0       = req0_valid & req0_ready;
    acc1       = req1_valid & req1_ready;
  end

  always_comb begin
    alu_out = '0;
    case (op_q)
      2'b00:   alu_out = {1'b0, a_q & b_q};
      2'b01:   alu_out = {1'b0, a_q | b_q};
      2'b10:   alu_out = {1'b0, a_q ^ b_q};
      default: alu_out = {1'b0, a_q} + {1'b0, b_q};
    endcase
  end

  always_comb begin
    state_nx = S_IDLE;
    case (state)
      S_IDLE:  state_nx = (acc0 | acc1) ? S_EXEC : S_IDLE;
      S_EXEC:  state_nx = S_RESP;
      S_RESP:  state_nx = res_ready ? S_IDLE : S_RESP;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
      last_grant <= 1'b1;
      res_valid  <= 1'b0;
      res_y      <= '0;
      res_cout   <= 1'b0;
      res_id     <= 1'b0;
    end else begin
      state <= state_nx;
      if (acc0 | acc1) begin
        op_q       <= acc1 ? req1_op : req0_op;
        a_q        <= acc1 ? req1_a  : req0_a;
        b_q        <= acc1 ? req1_b  : req0_b;
        id_q       <= acc1;
        last_grant <= acc1;
      end
      if (state == S_EXEC) begin
        res_y    <= alu_out[WIDTH-1:0];
        res_cout <= alu_out[WIDTH];
        res_id   <= id_q;
      end
      // Valid exactly while the FSM sits in RESP; the result regs hold meanwhile.
      res_valid <= (state_nx == S_RESP);
    end
  end

  assign busy = (state != S_IDLE);

`ifdef ALU_SHARE_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt0 <= 8'h00;
      grant_cnt1 <= 8'h00;
    end else begin
      if (acc0 && grant_cnt0 != 8'hFF) grant_cnt0 <= grant_cnt0 + 8'h01;
      if (acc1 && grant_cnt1 != 8'hFF) grant_cnt1 <= grant_cnt1 + 8'h01;
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - self-checking bench for alu_share_arbiter

module tb_alu_share_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [1:0] req0_op = '0, req1_op = '0;
  logic [3:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic       res_valid, res_ready = 1'b1;
  logic [3:0] res_y;
  logic       res_cout, res_id, busy;
`ifdef ALU_SHARE_ARB_STATS_EN
  logic [7:0] grant_cnt0, grant_cnt1;
`endif

  alu_share_arbiter #(.WIDTH(4), .OPW(2)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_y(res_y),
    .res_cout(res_cout), .res_id(res_id), .busy(busy)
`ifdef ALU_SHARE_ARB_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: "one op in flight" plus "result presented" flags.
  logic       m_inflight = 1'b0, m_has_res = 1'b0, m_lastg = 1'b1;
  logic [3:0] m_y = '0, p_y = '0;
  logic       m_c = 1'b0, m_id = 1'b0, p_c = 1'b0, p_id = 1'b0;

  function automatic logic [4:0] ref_alu(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    int s;
    case (op)
      2'd0: return {1'b0, a & b};
      2'd1: return {1'b0, a | b};
      2'd2: return {1'b0, a ^ b};
      default: begin
        s = int'(a) + int'(b);
        return {s > 15, 4'(s % 16)};
      end
    endcase
  endfunction

  // bit0 = requester 0 granted, bit1 = requester 1 granted
  function automatic logic [1:0] m_grant();
    if (rst || m_inflight) return 2'b00;
    if (req0_valid && req1_valid) return m_lastg ? 2'b01 : 2'b10;
    return {req1_valid, req0_valid};
  endfunction

  always @(posedge clk) begin
    logic [1:0] g;
    logic [4:0] r;
    g = m_grant();
    if (rst) begin
      m_inflight = 0; m_has_res = 0; m_lastg = 1;
      m_y = 0; m_c = 0; m_id = 0;
    end else if (!m_inflight) begin
      if (g != 2'b00) begin
        r = g[1] ? ref_alu(req1_op, req1_a, req1_b) : ref_alu(req0_op, req0_a, req0_b);
        p_y = r[3:0]; p_c = r[4]; p_id = g[1];
        m_lastg = g[1];
        m_inflight = 1;
      end
    end else if (!m_has_res) begin
      m_has_res = 1; m_y = p_y; m_c = p_c; m_id = p_id;
    end else if (res_ready) begin
      m_has_res = 0; m_inflight = 0;
    end
  end

  logic chk_on = 1'b0;
  always @(negedge clk) begin
    logic [1:0] g;
    if (chk_on) begin
      g = m_grant();
      chk("m_ready0", req0_ready, g[0]);
      chk("m_ready1", req1_ready, g[1]);
      chk("m_res_valid", res_valid, m_has_res);
      chk("m_busy", busy, m_inflight);
      chk("m_res_y", res_y, m_y);
      chk("m_res_cout", res_cout, m_c);
      chk("m_res_id", res_id, m_id);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; req0_valid = 0; req1_valid = 0;
    cyc(); cyc();
    rst = 0;
  endtask

  // Single op from IDLE with res_ready=1; checks accept, N+1, N+2 and return to IDLE.
  task automatic run_op(input logic id, input logic [1:0] op, input logic [3:0] a,
                        input logic [3:0] b, input logic [3:0] ey, input logic ec);
    res_ready = 1;
    req0_valid = !id; req1_valid = id;
    if (id) begin req1_op = op; req1_a = a; req1_b = b; end
    else    begin req0_op = op; req0_a = a; req0_b = b; end
    #1;
    chk("op_ready_own", id ? req1_ready : req0_ready, 1);
    chk("op_ready_other", id ? req0_ready : req1_ready, 0);
    cyc();
    req0_valid = 0; req1_valid = 0;
    chk("op_n1_valid", res_valid, 0);
    chk("op_n1_busy", busy, 1);
    cyc();
    chk("op_n2_valid", res_valid, 1);
    chk("op_y", res_y, ey);
    chk("op_cout", res_cout, ec);
    chk("op_id", res_id, id);
    cyc();
    chk("op_idle_valid", res_valid, 0);
    chk("op_idle_busy", busy, 0);
  endtask

  typedef struct {
    logic       id;
    logic [1:0] op;
    logic [3:0] a, b, y;
    logic       c;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int gcount;
    logic [3:0] hy;
    logic hc, hid;
    logic [4:0] r;

    tbl[0] = '{id: 1'b0, op: 2'd0, a: 4'b1100, b: 4'b1010, y: 4'b1000, c: 1'b0};
    tbl[1] = '{id: 1'b1, op: 2'd3, a: 4'hF,    b: 4'h1,    y: 4'h0,    c: 1'b1};
    tbl[2] = '{id: 1'b0, op: 2'd2, a: 4'h5,    b: 4'hF,    y: 4'hA,    c: 1'b0};
    tbl[3] = '{id: 1'b1, op: 2'd1, a: 4'h3,    b: 4'h8,    y: 4'hB,    c: 1'b0};
    tbl[4] = '{id: 1'b0, op: 2'd3, a: 4'h7,    b: 4'h8,    y: 4'hF,    c: 1'b0};
    tbl[5] = '{id: 1'b1, op: 2'd3, a: 4'hA,    b: 4'hB,    y: 4'h5,    c: 1'b1};
    tbl[6] = '{id: 1'b1, op: 2'd0, a: 4'hF,    b: 4'hF,    y: 4'hF,    c: 1'b0};

    do_reset();
    chk_on = 1;
    chk("rst_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_y", res_y, 0);
    chk("rst_cout", res_cout, 0);
    chk("rst_id", res_id, 0);

    foreach (tbl[i]) run_op(tbl[i].id, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].y, tbl[i].c);

    // Round-robin: both valid continuously
    do_reset();
    res_ready = 1; req0_valid = 1; req1_valid = 1;
    req0_op = 2'd3; req1_op = 2'd1;
    gcount = 0;
    for (int k = 0; k < 12; k++) begin
      #1;
      chk("rr_excl", req0_ready & req1_ready, 0);
      if (req0_ready || req1_ready) begin
        chk("rr_order", req1_ready, gcount % 2);
        gcount++;
      end
      cyc();
    end
    chk("rr_count", gcount, 4);
    req0_valid = 0; req1_valid = 0;
    cyc(); cyc(); cyc();

    // Backpressure: result held for 5 cycles
    do_reset();
    res_ready = 0;
    req0_valid = 1; req0_op = 2'd3; req0_a = 4'h9; req0_b = 4'h9;
    #1 chk("bp_accept", req0_ready, 1);
    cyc();
    req1_valid = 1;
    chk("bp_exec_noready", req0_ready | req1_ready, 0);
    cyc();
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", res_valid, 1);
      chk("bp_y", res_y, 4'h2);
      chk("bp_cout", res_cout, 1);
      chk("bp_id", res_id, 0);
      chk("bp_noready", req0_ready | req1_ready, 0);
      chk("bp_busy", busy, 1);
      cyc();
    end
    res_ready = 1;
    #1 chk("bp_consume_noready", req0_ready | req1_ready, 0);
    cyc();
    chk("bp_next_accept", req1_ready, 1);
    chk("bp_next_excl", req0_ready, 0);
    cyc();
    req0_valid = 0; req1_valid = 0;
    cyc(); cyc();

    // Reset during EXEC
    do_reset();
    res_ready = 0;
    req1_valid = 1; req1_op = 2'd3; req1_a = 4'h3; req1_b = 4'h4;
    cyc();
    req0_valid = 1; rst = 1;
    #1 chk("rstx_noready", req0_ready | req1_ready, 0);
    cyc();
    rst = 0;
    #1;
    chk("rstx_valid", res_valid, 0);
    chk("rstx_busy", busy, 0);
    chk("rstx_tie0", req0_ready, 1);
    req0_valid = 0; req1_valid = 0;
    cyc();

    // Reset during RESP
    req1_valid = 1;
    cyc();
    req1_valid = 0;
    cyc(); cyc();
    chk("rstr_pre_valid", res_valid, 1);
    rst = 1; req0_valid = 1; req1_valid = 1;
    cyc();
    rst = 0;
    #1;
    chk("rstr_valid", res_valid, 0);
    chk("rstr_busy", busy, 0);
    chk("rstr_tie0", req0_ready, 1);
    req0_valid = 0; req1_valid = 0;
    cyc();

    // Random stimulus against the model
    for (int k = 0; k < 800; k++) begin
      req0_valid = 1'($urandom % 2); req1_valid = 1'($urandom % 2);
      req0_op = 2'($urandom); req1_op = 2'($urandom);
      req0_a = 4'($urandom); req0_b = 4'($urandom);
      req1_a = 4'($urandom); req1_b = 4'($urandom);
      res_ready = ($urandom % 4) != 0;
      rst = ($urandom % 64) == 0;
      cyc();
    end
    rst = 0;

`ifdef ALU_SHARE_ARB_STATS_EN
    do_reset();
    chk("st_cnt0_rst", grant_cnt0, 0);
    chk("st_cnt1_rst", grant_cnt1, 0);
    for (int k = 0; k < 300; k++) begin
      hy = 4'($urandom); r = ref_alu(2'd3, hy, 4'hC);
      run_op(1'b0, 2'd3, hy, 4'hC, r[3:0], r[4]);
    end
    chk("st_cnt0_sat", grant_cnt0, 8'hFF);
    chk("st_cnt1_zero", grant_cnt1, 0);
`endif

    hid = res_id; hc = res_cout;
    chk_on = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one WIDTH-bit ALU (AND, OR, XOR, ADD) between two requesters.
- Round-robin arbitration with valid/ready handshakes.
- Operations are sequenced through a fixed IDLE→EXEC→RESP flow, so exactly one operation is in flight at a time.
- Sits between requester logic and the result consumer in the ALU project top level. It is the only owner of the shared ALU datapath.

Parameters:
- WIDTH, 4, operand/result width in bits.
- OPW, 2, opcode width. Fixed at 2; other values are unsupported.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_op  input  OPW  00=AND 01=OR 10=XOR 11=ADD
- req0_a  input  WIDTH  operand A
- req0_b  input  WIDTH  operand B
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0, for requester 1
- res_valid  output  1  result available
- res_ready  input  1  consumer takes result
- res_y  output  WIDTH  result
- res_cout  output  1  ADD carry-out; 0 for logic ops
- res_id  output  1  requester that issued the result
- busy  output  1  high in EXEC or RESP

Behaviour:
- Reset values (rst sampled high at posedge): state=IDLE; res_valid=0; res_y=0; res_cout=0; res_id=0; busy=0; last_grant=1, so requester 0 wins the first tie. Reset mid-operation discards the in-flight op and any held result; no result is ever emitted for it.
- reqN_ready is combinational:
  - asserted only in IDLE, only for the granted requester.
  - never asserted during reset.
  - never asserted for both requesters in the same cycle.
- Arbitration in IDLE:
  - Only one valid: grant it.
  - Both valid: grant the requester other than last_grant.
  - The handshake (valid & ready) latches op, a, b and id; last_grant updates to the granted id; next state is EXEC.
- EXEC (one cycle):
  - Compute from the latched operands.
  - Logic ops: bitwise, res_cout=0.
  - ADD: {cout,y} = a + b, WIDTH+1 bits; wrap-around, e.g. 4'hF+4'h1 gives y=0, cout=1.
  - Register res_y, res_cout, res_id; set res_valid=1; next state is RESP.
- RESP:
  - res_y, res_cout and res_id stay stable while res_valid=1 and res_ready=0.
  - On res_ready=1: clear res_valid, go to IDLE.
  - No new accept in that same cycle. The earliest next accept is the following cycle.
- Latency: accept at cycle N, res_valid high from N+2. Best-case throughput is one op per 3 cycles.
- res_ready while res_valid=0 is ignored.
- Requester inputs are don't-care outside the accepting cycle.
- A requester dropping valid before being granted is legal; no state changes.
- busy = (state != IDLE).
- Illegal state encodings recover to IDLE on the next clock.

Optional Feature:
- Macro: ALU_SHARE_ARB_STATS_EN.
- When defined, add outputs grant_cnt0 and grant_cnt1, 8 bits each:
  - Reset to 0.
  - Increment on each accepted handshake of the respective requester.
  - Saturate at 8'hFF (no wrap).
- When undefined, these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then single op: req0 AND a=4'b1100 b=4'b1010, res_ready=1 → req0_ready high the same cycle, res_valid at N+2 with res_y=4'b1000, res_cout=0, res_id=0, then back to IDLE.
- ADD wrap: req1 ADD a=4'hF b=4'h1 → res_y=4'h0, res_cout=1, res_id=1. Also check XOR 4'h5^4'hF=4'hA and OR 4'h3|4'h8=4'hB.
- Round-robin: both valid continuously with res_ready=1 → grants alternate 0,1,0,1 over four ops, and req0_ready/req1_ready are never both high.
- Backpressure: res_ready=0 for 5 cycles after res_valid → res_y/res_cout/res_id stable, no reqN_ready asserted, busy=1. After res_ready=1 the next accept occurs exactly one cycle later.
- Reset mid-op: assert rst in EXEC and again in RESP → next cycle res_valid=0, busy=0, state IDLE; a tie afterwards grants requester 0.
- With ALU_SHARE_ARB_STATS_EN: 300 req0-only ops → grant_cnt0=8'hFF (saturated), grant_cnt1=0.
